byte_fetch_unit: RTL and testbench

BYTE_FETCH_UNIT -- requirements
Module: byte_fetch_unit

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/byte_lane_reg.sv | 27 ++
 rtl/byte_fetch_unit.sv | 125 ++++++++++++
 tb/tb_byte_fetch_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the byte fetch unit.
// Byte order is selected at build time by BYTE_FETCH_BIG_ENDIAN_EN (see byte_fetch_unit).
package fetch_pkg;

  localparam int NUM_BYTES = 4;
  localparam int BYTE_W    = 8;
  localparam int WORD_W    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Byte address of the read after the one at offset cnt, wrapping modulo 256.
  function automatic logic [BYTE_W-1:0] next_addr(input logic [BYTE_W-1:0] base,
                                                  input logic [1:0]        cnt);
    return base + {6'd0, cnt} + 8'd1;
  endfunction

endpackage

// File: rtl/byte_lane_reg.sv
// One byte lane of the assembled word: 8-bit register with load enable.
module byte_lane_reg
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic [BYTE_W-1:0] d_i,
  output logic [BYTE_W-1:0] q_o
);

  logic [BYTE_W-1:0] lane_q;

  // Capture the incoming byte when loaded; otherwise keep the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_q <= 8'h00;
    end else if (load_i) begin
      lane_q <= d_i;
    end else begin
      lane_q <= lane_q;
    end
  end

  assign q_o = lane_q;

endmodule

// File: rtl/byte_fetch_unit.sv
// Fetches four consecutive bytes from an 8-bit synchronous memory and
// presents them as one 32-bit word with a valid/ready handshake.
// Build option: BYTE_FETCH_BIG_ENDIAN_EN puts lane 0 (lowest address) in
// word[31:24]; without it lane 0 sits in word[7:0]. Timing is unchanged.
module byte_fetch_unit
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [BYTE_W-1:0] base_addr,
  output logic              mem_rd,
  output logic [BYTE_W-1:0] mem_addr,
  input  logic [BYTE_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy
);

  state_e            state_q;
  logic [1:0]        cnt_q;
  logic [BYTE_W-1:0] base_q;
  logic              mem_rd_q;
  logic [BYTE_W-1:0] mem_addr_q;
  logic              word_valid_q;
  logic              busy_q;

  logic [NUM_BYTES-1:0] lane_ld_d;
  logic [BYTE_W-1:0]    lane_s [NUM_BYTES];
  logic [WORD_W-1:0]    word_s;

  // Control FSM; every output it drives is a register set one edge ahead.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      base_q       <= 8'h00;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= 8'h00;
      word_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= FETCH;
            base_q     <= base_addr;
            cnt_q      <= 2'd0;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= base_addr;
            busy_q     <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        FETCH: begin
          // cnt wraps back to 0 after the fourth read.
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_q  <= DRAIN;
            mem_rd_q <= 1'b0;
          end else begin
            state_q    <= FETCH;
            mem_addr_q <= next_addr(base_q, cnt_q);
          end
        end
        DRAIN: begin
          state_q      <= HOLD;
          word_valid_q <= 1'b1;
        end
        HOLD: begin
          if (word_ready) begin
            state_q      <= IDLE;
            word_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end else begin
            state_q <= HOLD;
          end
        end
        default: begin
          state_q      <= IDLE;
          cnt_q        <= 2'd0;
          mem_rd_q     <= 1'b0;
          word_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  // Read data trails the strobe by one cycle, so the lane being filled is cnt-1.
  always_comb begin
    lane_ld_d = {NUM_BYTES{1'b0}};
    if ((state_q == FETCH) && (cnt_q != 2'd0)) begin
      lane_ld_d[cnt_q - 2'd1] = 1'b1;
    end else if (state_q == DRAIN) begin
      lane_ld_d[NUM_BYTES-1] = 1'b1;
    end else begin
      lane_ld_d = {NUM_BYTES{1'b0}};
    end
  end

  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
    byte_lane_reg u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (lane_ld_d[i]),
      .d_i     (mem_rdata),
      .q_o     (lane_s[i])
    );
`ifdef BYTE_FETCH_BIG_ENDIAN_EN
    assign word_s[WORD_W-1-i*BYTE_W -: BYTE_W] = lane_s[i];
`else
    assign word_s[i*BYTE_W +: BYTE_W] = lane_s[i];
`endif
  end

  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign word       = word_s;
  assign word_valid = word_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_byte_fetch_unit.sv
// Directed scoreboard bench for byte_fetch_unit; memory returns addr+0x10.
module tb_byte_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  base_addr;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic [31:0] word;
  logic        word_valid;
  logic        word_ready;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  addr_q [$];
  logic [31:0] word_q [$];
  logic        prev_v = 1'b0;

  byte_fetch_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // 1-cycle synchronous memory model.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem_addr + 8'h10;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [7:0] b);
    logic [31:0] w;
    logic [7:0]  d;
    w = 32'd0;
    for (int i = 0; i < 4; i++) begin
      d = b + 8'(i) + 8'h10;
`ifdef BYTE_FETCH_BIG_ENDIAN_EN
      w[31-8*i -: 8] = d;
`else
      w[8*i +: 8] = d;
`endif
    end
    return w;
  endfunction

  // Monitor: every read strobe and every new valid word is checked against the scoreboard.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (mem_rd === 1'b1) begin
        if (addr_q.size() == 0) check("spurious_rd", 32'(mem_rd), 32'd0);
        else check("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
      end
      if ((word_valid === 1'b1) && !prev_v) begin
        if (word_q.size() == 0) check("spurious_valid", 32'(word_valid), 32'd0);
        else check("word", word, word_q.pop_front());
      end
    end
    prev_v = (word_valid === 1'b1);
  end

  // Issue one start, queue expectations, and measure start-to-valid latency.
  task automatic run_fetch(input logic [7:0] b);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    for (int i = 0; i < 4; i++) addr_q.push_back(b + 8'(i));
    word_q.push_back(exp_word(b));
    @(posedge clk);
    #1;
    start = 1'b0;
    base_addr = 8'h00;
    cyc = 0;
    while ((word_valid !== 1'b1) && (cyc < 20)) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'd6);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    reset_n = 1'b0;
    start = 1'b0;
    base_addr = 8'h00;
    word_ready = 1'b0;
    #12;
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_word", word, 32'd0);
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic fetch; ready held high the whole time, so it has no effect before HOLD.
    word_ready = 1'b1;
    run_fetch(8'h20);
    @(negedge clk);
    check("idle_after_xfer_busy", 32'(busy), 32'd0);
    check("valid_after_xfer", 32'(word_valid), 32'd0);
    check("word_held_after_xfer", word, exp_word(8'h20));

    // Address wrap.
    run_fetch(8'hFE);
    repeat (2) @(negedge clk);
    check("wrap_busy", 32'(busy), 32'd0);
    check("addr_q_empty", 32'(addr_q.size()), 32'd0);

    // Backpressure with ignored start pulses during HOLD.
    word_ready = 1'b0;
    run_fetch(8'h55);
    held = exp_word(8'h55);
    for (int k = 0; k < 10; k++) begin
      start = k[0];
      base_addr = 8'h99;
      @(negedge clk);
      check("bp_valid", 32'(word_valid), 32'd1);
      check("bp_word", word, held);
    end
    start = 1'b1;
    word_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    word_ready = 1'b0;
    check("bp_idle_busy", 32'(busy), 32'd0);
    check("bp_idle_valid", 32'(word_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("bp_no_restart", 32'(busy), 32'd0);
    check("bp_word_held", word, held);

    // Asynchronous reset during FETCH with cnt=2.
    @(negedge clk);
    start = 1'b1;
    base_addr = 8'h30;
    for (int i = 0; i < 4; i++) addr_q.push_back(8'h30 + 8'(i));
    word_q.push_back(exp_word(8'h30));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_mem_rd", 32'(mem_rd), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(word_valid), 32'd0);
    check("mid_rst_word", word, 32'd0);
    addr_q.delete();
    word_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    word_ready = 1'b1;
    run_fetch(8'h40);
    repeat (3) @(negedge clk);
    check("final_busy", 32'(busy), 32'd0);
    check("final_word_q_empty", 32'(word_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
